// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller user port between NPORTS clients: round-robin
// (optionally port-0 priority) grant, with a tag FIFO steering read data back.
module sdram_port_arbiter #(
    parameter int unsigned NPORTS = 3,
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned MAX_RD = 4,
    parameter int unsigned PRIO0  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NPORTS*ADDR_W-1:0]   p_addr,
    input  logic [NPORTS*DATA_W-1:0]   p_wdata,
    input  logic [NPORTS-1:0]          p_wr,
    input  logic [NPORTS-1:0]          p_rd,
    output logic [NPORTS-1:0]          p_ack,
    output logic [NPORTS-1:0]          p_val,
    output logic [DATA_W-1:0]          p_rdata,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_wr,
    output logic                       mem_rd,
    input  logic                       mem_rdy,
    input  logic                       mem_val,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       rd_overflow
);

    localparam int unsigned PTR_W = $clog2(NPORTS);
    localparam int unsigned FA_W  = $clog2(MAX_RD);
    localparam int unsigned CNT_W = FA_W + 1;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  tag_mem_q [MAX_RD];
    logic [FA_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FA_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NPORTS-1:0] p_val_q, p_val_d;
    logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
    logic              ovf_q, ovf_d;

    logic [NPORTS-1:0] elig;
    logic              fifo_full;
    logic              any_elig;
    logic              hi_found;
    logic [PTR_W-1:0]  hi_win;
    logic [PTR_W-1:0]  lo_win;
    logic [PTR_W-1:0]  win;
    logic              win_wr;
    logic              accept;
    logic              push;
    logic              pop;

    // Winner selection: lowest eligible index at/after rr_ptr, else wrap to lowest overall.
    always_comb begin
        fifo_full = (count_q == CNT_W'(MAX_RD));
        elig      = p_wr | (p_rd & {NPORTS{~fifo_full}});
        any_elig  = |elig;
        hi_found  = 1'b0;
        hi_win    = '0;
        lo_win    = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_win = PTR_W'(i);
                if (PTR_W'(i) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_win   = PTR_W'(i);
                end
            end
        end
        if ((PRIO0 != 0) && elig[0]) begin
            win = '0;
        end else if (hi_found) begin
            win = hi_win;
        end else if (any_elig) begin
            win = lo_win;
        end else begin
            win = rr_ptr_q;
        end
    end

    // Request mux; idle selects rr_ptr's fields so the bus stays stable.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        win_wr    = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (PTR_W'(i) == win) begin
                mem_addr  = p_addr[i*ADDR_W +: ADDR_W];
                mem_wdata = p_wdata[i*DATA_W +: DATA_W];
                win_wr    = p_wr[i];
            end
        end
        mem_wr = rst_n & any_elig & win_wr;
        mem_rd = rst_n & any_elig & ~win_wr;
    end

    always_comb begin
        accept    = mem_rdy & (mem_wr | mem_rd);
        p_ack     = accept ? (NPORTS'(1) << win) : '0;
        push      = accept & mem_rd;
        pop       = mem_val & (count_q != '0);
        rr_ptr_d  = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (win == PTR_W'(NPORTS - 1)) ? '0 : win + 1'b1;
        end
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        p_val_d   = pop ? (NPORTS'(1) << tag_mem_q[rd_ptr_q]) : '0;
        p_rdata_d = pop ? mem_rdata : p_rdata_q;
        ovf_d     = ovf_q | (mem_val & (count_q == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            p_val_q   <= '0;
            p_rdata_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            p_val_q   <= p_val_d;
            p_rdata_q <= p_rdata_d;
            ovf_q     <= ovf_d;
        end
    end

    // Tag storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= win;
        end
    end

    assign p_val       = p_val_q;
    assign p_rdata     = p_rdata_q;
    assign rd_overflow = ovf_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: round-robin and port-0-priority instances
// driven in parallel, checked each cycle against a queue-based model.
module tb_sdram_port_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 25;
    localparam int unsigned DW = 8;
    localparam int unsigned MR = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*AW-1:0] p_addr = '0;
    logic [N*DW-1:0] p_wdata = '0;
    logic [N-1:0]    p_wr = '0;
    logic [N-1:0]    p_rd = '0;
    logic            mem_rdy = 1'b0;
    logic            mem_val = 1'b0;
    logic [DW-1:0]   mem_rdata = '0;

    logic [N-1:0]    ack    [2];
    logic [N-1:0]    val    [2];
    logic [DW-1:0]   rdata  [2];
    logic [AW-1:0]   addr_o [2];
    logic [DW-1:0]   wdat_o [2];
    logic            wr_o   [2];
    logic            rd_o   [2];
    logic            ovf    [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.NPORTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_RD(MR), .PRIO0(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .p_addr(p_addr), .p_wdata(p_wdata), .p_wr(p_wr), .p_rd(p_rd),
        .p_ack(ack[0]), .p_val(val[0]), .p_rdata(rdata[0]), .mem_addr(addr_o[0]),
        .mem_wdata(wdat_o[0]), .mem_wr(wr_o[0]), .mem_rd(rd_o[0]), .mem_rdy(mem_rdy),
        .mem_val(mem_val), .mem_rdata(mem_rdata), .rd_overflow(ovf[0])
    );

    sdram_port_arbiter #(.NPORTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_RD(MR), .PRIO0(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .p_addr(p_addr), .p_wdata(p_wdata), .p_wr(p_wr), .p_rd(p_rd),
        .p_ack(ack[1]), .p_val(val[1]), .p_rdata(rdata[1]), .mem_addr(addr_o[1]),
        .mem_wdata(wdat_o[1]), .mem_wr(wr_o[1]), .mem_rd(rd_o[1]), .mem_rdy(mem_rdy),
        .mem_val(mem_val), .mem_rdata(mem_rdata), .rd_overflow(ovf[1])
    );

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d) at %0t: got %h expected %h", nm, d, $time, act, exp);
        end
    endtask

    // Reference model per instance: arbitration by modular scan, tags in a queue.
    for (genvar d = 0; d < 2; d++) begin : g_model
        localparam bit PRIO = (d == 1);
        int          rr;
        int          tq [$];
        int          win;
        int          t;
        logic [N-1:0] elig;
        logic [N-1:0] e_val;
        logic [DW-1:0] e_rdata;
        logic        e_ovf;
        logic        e_wr;
        logic        e_rd;
        logic        acc;

        always @(negedge clk) begin
            if (!rst_n) begin
                rr = 0;
                tq.delete();
                e_val   = '0;
                e_rdata = '0;
                e_ovf   = 1'b0;
                chk("rst_ack",   d, 32'(ack[d]),   32'd0);
                chk("rst_wr",    d, 32'(wr_o[d]),  32'd0);
                chk("rst_rd",    d, 32'(rd_o[d]),  32'd0);
                chk("rst_val",   d, 32'(val[d]),   32'd0);
                chk("rst_rdata", d, 32'(rdata[d]), 32'd0);
                chk("rst_ovf",   d, 32'(ovf[d]),   32'd0);
            end else begin
                for (int i = 0; i < N; i++) begin
                    elig[i] = p_wr[i] | (p_rd[i] & (tq.size() < MR));
                end
                win = -1;
                if (PRIO && elig[0]) begin
                    win = 0;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (win < 0 && elig[(rr + k) % N]) win = (rr + k) % N;
                    end
                end
                e_wr = 1'b0;
                e_rd = 1'b0;
                if (win >= 0) begin
                    e_wr = p_wr[win];
                    e_rd = !p_wr[win];
                end
                acc = mem_rdy & (e_wr | e_rd);
                chk("mem_wr",  d, 32'(wr_o[d]),  32'(e_wr));
                chk("mem_rd",  d, 32'(rd_o[d]),  32'(e_rd));
                chk("p_ack",   d, 32'(ack[d]),   acc ? 32'(1) << win : 32'd0);
                chk("p_val",   d, 32'(val[d]),   32'(e_val));
                chk("p_rdata", d, 32'(rdata[d]), 32'(e_rdata));
                chk("rd_ovf",  d, 32'(ovf[d]),   32'(e_ovf));
                if (win >= 0) chk("mem_addr", d, 32'(addr_o[d]), 32'(p_addr[win*AW +: AW]));
                if (e_wr) chk("mem_wdata", d, 32'(wdat_o[d]), 32'(p_wdata[win*DW +: DW]));

                if (acc) rr = (win + 1) % N;
                e_val = '0;
                if (mem_val) begin
                    if (tq.size() > 0) begin
                        t       = tq.pop_front();
                        e_val   = N'(1) << t;
                        e_rdata = mem_rdata;
                    end else begin
                        e_ovf = 1'b1;
                    end
                end
                if (acc && e_rd) tq.push_back(win);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n   = 1'b0;
        p_wr    = '0;
        p_rd    = '0;
        mem_val = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        p_addr[p*AW +: AW] = a;
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;

        // Single read from port 1, data returned three cycles later.
        do_reset();
        set_addr(1, 25'h0000123);
        mem_rdy = 1'b1;
        p_rd    = 3'b010;
        at_neg();
        chk("s1_ack",  0, 32'(ack[0]),    32'h2);
        chk("s1_rd",   0, 32'(rd_o[0]),   32'h1);
        chk("s1_addr", 0, 32'(addr_o[0]), 32'h123);
        tick();
        p_rd = '0;
        tick();
        tick();
        mem_val   = 1'b1;
        mem_rdata = 8'hA5;
        tick();
        mem_val = 1'b0;
        at_neg();
        chk("s1_val",   0, 32'(val[0]),   32'h2);
        chk("s1_rdata", 0, 32'(rdata[0]), 32'hA5);

        // All ports writing: strict rotation.
        do_reset();
        for (int i = 0; i < N; i++) p_wdata[i*DW +: DW] = 8'(8'h10 + i);
        p_wr = 3'b111;
        for (int c = 0; c < 6; c++) begin
            at_neg();
            chk("s2_ack",   0, 32'(ack[0]),    32'(1) << (c % 3));
            chk("s2_wdata", 0, 32'(wdat_o[0]), 32'(8'h10 + (c % 3)));
            tick();
        end
        p_wr = '0;

        // Controller stalled, then released.
        do_reset();
        mem_rdy = 1'b0;
        p_wr    = 3'b101;
        for (int c = 0; c < 5; c++) begin
            at_neg();
            chk("s3_stall", 0, 32'(ack[0]), 32'd0);
            tick();
        end
        mem_rdy = 1'b1;
        at_neg();
        chk("s3_first", 0, 32'(ack[0]), 32'h1);
        tick();
        p_wr = 3'b100;
        at_neg();
        chk("s3_second", 0, 32'(ack[0]), 32'h4);
        tick();
        p_wr = '0;

        // Tag FIFO full blocks reads but not writes.
        do_reset();
        p_rd = 3'b001;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            chk("s4_fill", 0, 32'(ack[0]), 32'h1);
            tick();
        end
        p_rd = 3'b010;
        p_wr = 3'b100;
        at_neg();
        chk("s4_wr_ok", 0, 32'(ack[0]), 32'h4);
        tick();
        p_wr = '0;
        at_neg();
        chk("s4_block", 0, 32'(ack[0]), 32'd0);
        chk("s4_no_rd", 0, 32'(rd_o[0]), 32'd0);
        tick();
        mem_val   = 1'b1;
        mem_rdata = 8'h5A;
        at_neg();
        chk("s4_still_full", 0, 32'(ack[0]), 32'd0);
        tick();
        mem_val = 1'b0;
        at_neg();
        chk("s4_unblock", 0, 32'(ack[0]),   32'h2);
        chk("s4_val",     0, 32'(val[0]),   32'h1);
        chk("s4_rdata",   0, 32'(rdata[0]), 32'h5A);
        tick();
        p_rd = '0;

        // Port 0 priority instance.
        do_reset();
        p_wr = 3'b011;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            chk("s5_prio", 1, 32'(ack[1]), 32'h1);
            tick();
        end
        p_wr = 3'b010;
        at_neg();
        chk("s5_port1", 1, 32'(ack[1]), 32'h2);
        tick();
        p_wr = '0;

        // Stray return data, then reset with reads outstanding.
        do_reset();
        mem_val = 1'b1;
        tick();
        mem_val = 1'b0;
        at_neg();
        chk("s6_ovf",    0, 32'(ovf[0]), 32'h1);
        chk("s6_no_val", 0, 32'(val[0]), 32'd0);
        tick();
        p_rd = 3'b001;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("s6_rst_rd",  0, 32'(rd_o[0]), 32'd0);
        chk("s6_rst_ack", 0, 32'(ack[0]),  32'd0);
        chk("s6_rst_ovf", 0, 32'(ovf[0]),  32'd0);
        tick();
        rst_n   = 1'b1;
        p_rd    = '0;
        mem_val = 1'b1;
        tick();
        mem_val = 1'b0;
        at_neg();
        chk("s6_empty_ovf", 0, 32'(ovf[0]), 32'h1);
        chk("s6_empty_val", 0, 32'(val[0]), 32'd0);

        // Mixed traffic checked only by the model.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                p_addr[i*AW +: AW]  = AW'($urandom);
                p_wdata[i*DW +: DW] = DW'($urandom);
            end
            p_wr      = N'($urandom_range(0, 7) & $urandom_range(0, 7));
            p_rd      = N'($urandom_range(0, 7));
            mem_rdy   = ($urandom_range(0, 3) != 0);
            mem_val   = ($urandom_range(0, 2) == 0);
            mem_rdata = DW'($urandom);
            tick();
        end
        do_reset();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single user port of the SDRAM controller (8-bit data, 25-bit byte address, rd/wr/rdy/val handshake) between NPORTS requesters, e.g. CPU, PPU and loader.
- Round-robin grant, with optional strict priority for port 0 (the real-time client).
- A tag FIFO records which port issued each outstanding read. In-order read data from the controller is routed back to that port.
- Sits directly between client logic and the controller's user interface.

Parameters:
- NPORTS, 3, number of requesters (2..8).
- ADDR_W, 25, address width; matches the controller.
- DATA_W, 8, data width; matches the controller.
- MAX_RD, 4, max outstanding reads; tag FIFO depth (power of 2, ≥2).
- PRIO0, 0, 1 = port 0 has strict priority over the round-robin among other ports.

Ports:
- clk  in  1  system clock; the SDRAM clock domain.
- rst_n  in  1  asynchronous active-low reset.
- p_addr  in  NPORTS*ADDR_W  per-port address; port i at [i*ADDR_W +: ADDR_W].
- p_wdata  in  NPORTS*DATA_W  per-port write data.
- p_wr  in  NPORTS  per-port write request; held until ack.
- p_rd  in  NPORTS  per-port read request; held until ack.
- p_ack  out  NPORTS  one-hot pulse: the request was accepted this cycle.
- p_val  out  NPORTS  one-hot pulse: read data for that port is on p_rdata.
- p_rdata  out  DATA_W  returned read data; shared by all ports.
- mem_addr  out  ADDR_W  to controller addr_in.
- mem_wdata  out  DATA_W  to controller data_wr.
- mem_wr  out  1  to controller wr.
- mem_rd  out  1  to controller rd.
- mem_rdy  in  1  from controller rdy.
- mem_val  in  1  from controller val.
- mem_rdata  in  DATA_W  from controller data_rd.
- rd_overflow  out  1  sticky error flag: mem_val arrived with the tag FIFO empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rr_ptr=0, tag FIFO empty, p_val=0, p_rdata=0, rd_overflow=0.
  - mem_wr, mem_rd, p_ack forced 0 while rst_n is low.
- Eligibility: port i is eligible when p_wr[i] | (p_rd[i] & ~fifo_full).
  - If p_wr[i] and p_rd[i] are both high, it is a write; rd is ignored.
  - fifo_full is the registered state and ignores a same-cycle pop.
- Winner (combinational):
  - PRIO0=1 and port 0 eligible: winner is port 0.
  - Otherwise: first eligible port scanning rr_ptr, rr_ptr+1, … modulo NPORTS.
  - Under PRIO0=1 the scan still includes port 0.
- Request path (combinational, same cycle):
  - mem_addr/mem_wdata = winner's fields; mem_wr/mem_rd = winner's op when any port is eligible, else all 0.
  - mem_addr/mem_wdata are don't-care when idle, but must be stable.
- Accept = mem_rdy & (mem_wr | mem_rd). On accept:
  - p_ack[winner]=1, same cycle.
  - rr_ptr <= winner+1 mod NPORTS, registered.
  - If read: push the winner index into the tag FIFO.
- No accept: p_ack=0 and rr_ptr holds.
- Clients hold requests until acked. The arbiter latches nothing. A port that drops its request before ack is simply skipped.
- Read return, 1-cycle registered latency:
  - When mem_val=1: pop tag t; next cycle p_val[t]=1 and p_rdata=mem_rdata.
  - p_val is 0 in all other cycles; p_rdata holds its last value.
- Push and pop in the same cycle: both take effect and the count is unchanged.
  - If the FIFO was full, no push occurs, because a read cannot win.
- mem_val with the FIFO empty: no p_val pulse; rd_overflow set to 1 until reset.
- Wrap-around: FIFO pointers are log2(MAX_RD) bits, with a separate count of log2(MAX_RD)+1 bits. rr_ptr wraps NPORTS-1 → 0.
- Fairness: with PRIO0=0 and every port requesting continuously, each port is granted exactly once per NPORTS accepts.

Test Plan:
- Single read, port 1 addr 0x0000123, mem_rdy=1, model returns 0xA5 after 3 cycles:
  - p_ack=3'b010 on the request cycle.
  - mem_rd=1 with mem_addr=0x0000123.
  - p_val=3'b010 and p_rdata=0xA5 one cycle after mem_val.
- All 3 ports request writes continuously, PRIO0=0, mem_rdy=1: ack order 0,1,2,0,1,2. mem_wdata matches the acked port each cycle.
- mem_rdy=0 for 5 cycles with ports 0 and 2 requesting: p_ack=0 and rr_ptr unchanged. When mem_rdy rises, port 0 is acked first, then port 2.
- MAX_RD=4, port 0 issues 4 reads, no mem_val, port 1 requests a read and port 2 a write:
  - Port 2 is acked; port 1 blocked.
  - After one mem_val (tag 0), port 1 is acked the following cycle.
- PRIO0=1, ports 0 and 1 request continuously: port 0 acked every accept. When port 0 drops, port 1 is acked next cycle.
- Error and reset:
  - mem_val pulse with no outstanding reads: rd_overflow=1, p_val stays 0.
  - Assert rst_n=0 mid-burst with 2 reads outstanding: all outputs 0 immediately, FIFO empty after release.
